// File: rtl/main_memory.sv
// main_memory: shared line-wide backing store serving ICache refills and
// DCache line reads/writes, one transaction at a time.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   reqI_mem/reqAddrI_mem/memI_line/memI_data_rdy/memI_filled_ack
//                       instruction-side read request, returned line, ready, ack
//   reqD_mem/reqD_wrt/reqAddrD_mem/wrt_data_D/memD_line/memD_data_rdy/memD_filled_ack
//                       data-side read/write request, returned line, ready, ack
//
// Data wins arbitration in IDLE. Every accepted request spends LATENCY edges
// in BUSY, then sits in RESP with rdy high until the matching ack.
module main_memory #(
  parameter int LINE_W  = 128,
  parameter int ADDR_W  = 20,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqI_mem,
  input  logic [ADDR_W-1:0] reqAddrI_mem,
  output logic [LINE_W-1:0] memI_line,
  output logic              memI_data_rdy,
  input  logic              memI_filled_ack,
  input  logic              reqD_mem,
  input  logic              reqD_wrt,
  input  logic [ADDR_W-1:0] reqAddrD_mem,
  input  logic [LINE_W-1:0] wrt_data_D,
  output logic [LINE_W-1:0] memD_line,
  output logic              memD_data_rdy,
  input  logic              memD_filled_ack
);
  localparam int OFF_W = $clog2(LINE_W/8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_BUSY_I, S_BUSY_D, S_RESP_I, S_RESP_D
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wrt_q, wrt_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [LINE_W-1:0]  memI_line_q, memI_line_d;
  logic [LINE_W-1:0]  memD_line_q, memD_line_d;
  logic               mem_we;

  // Not reset: contents survive reset, never-written lines read as X.
  logic [LINE_W-1:0]  mem [DEPTH];

  // Offset and upper address bits carry no meaning here (lines wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{reqAddrI_mem[OFF_W-1:0], reqAddrI_mem[ADDR_W-1:OFF_W+IDX_W],
                              reqAddrD_mem[OFF_W-1:0], reqAddrD_mem[ADDR_W-1:OFF_W+IDX_W]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wrt_d       = wrt_q;
    wdata_d     = wdata_q;
    memI_line_d = memI_line_q;
    memD_line_d = memD_line_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reqD_mem) begin
          state_d = S_BUSY_D;
          idx_d   = reqAddrD_mem[OFF_W +: IDX_W];
          wrt_d   = reqD_wrt;
          wdata_d = wrt_data_D;
          cnt_d   = CNT_W'(LATENCY - 1);
        end else if (reqI_mem) begin
          state_d = S_BUSY_I;
          idx_d   = reqAddrI_mem[OFF_W +: IDX_W];
          wrt_d   = 1'b0;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      S_BUSY_I: begin
        if (cnt_q == '0) begin
          state_d     = S_RESP_I;
          memI_line_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BUSY_D: begin
        if (cnt_q == '0) begin
          state_d = S_RESP_D;
          if (wrt_q) begin
            mem_we      = 1'b1;
            memD_line_d = wdata_q;
          end else begin
            memD_line_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP_I: if (memI_filled_ack) state_d = S_IDLE;
      S_RESP_D: if (memD_filled_ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wrt_q       <= 1'b0;
      wdata_q     <= '0;
      memI_line_q <= '0;
      memD_line_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wrt_q       <= wrt_d;
      wdata_q     <= wdata_d;
      memI_line_q <= memI_line_d;
      memD_line_q <= memD_line_d;
    end
  end

  // A write landing on the same edge as reset is dropped with the transaction.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx_q] <= wdata_q;
  end

  assign memI_line     = memI_line_q;
  assign memD_line     = memD_line_q;
  assign memI_data_rdy = (state_q == S_RESP_I);
  assign memD_data_rdy = (state_q == S_RESP_D);
endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;
  localparam int LINE_W  = 128;
  localparam int ADDR_W  = 20;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              reqI_mem, memI_data_rdy, memI_filled_ack;
  logic [ADDR_W-1:0] reqAddrI_mem, reqAddrD_mem;
  logic [LINE_W-1:0] memI_line, memD_line, wrt_data_D;
  logic              reqD_mem, reqD_wrt, memD_data_rdy, memD_filled_ack;

  main_memory #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem), .memI_line(memI_line),
    .memI_data_rdy(memI_data_rdy), .memI_filled_ack(memI_filled_ack),
    .reqD_mem(reqD_mem), .reqD_wrt(reqD_wrt), .reqAddrD_mem(reqAddrD_mem),
    .wrt_data_D(wrt_data_D), .memD_line(memD_line), .memD_data_rdy(memD_data_rdy),
    .memD_filled_ack(memD_filled_ack)
  );

  always #5 clk = ~clk;

  // Reference model: plain array of lines indexed by (addr / 16) mod DEPTH.
  logic [LINE_W-1:0] model [DEPTH];
  int written [$];
  int total = 0, passed = 0, failed = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int line_idx(input logic [ADDR_W-1:0] a);
    return (int'(a) / (LINE_W/8)) % DEPTH;
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic get_rdy(input bit is_d);
    return is_d ? memD_data_rdy : memI_data_rdy;
  endfunction

  function automatic logic get_other_rdy(input bit is_d);
    return is_d ? memI_data_rdy : memD_data_rdy;
  endfunction

  function automatic logic [LINE_W-1:0] get_line(input bit is_d);
    return is_d ? memD_line : memI_line;
  endfunction

  // Entered at the negedge right after the acceptance edge T.
  task automatic resp_phase(input bit is_d, input logic [LINE_W-1:0] exp,
                            input int ack_dly, input bit stray);
    for (int k = 0; k < LATENCY; k++) begin
      chk("rdy_early", {127'b0, get_rdy(is_d)}, 128'd0);
      @(negedge clk);
    end
    chk("rdy_rise", {127'b0, get_rdy(is_d)}, 128'd1);
    chk("line", get_line(is_d), exp);
    chk("other_rdy", {127'b0, get_other_rdy(is_d)}, 128'd0);
    for (int j = 0; j < ack_dly; j++) begin
      if (stray) begin
        if (is_d) memI_filled_ack = 1'b1; else memD_filled_ack = 1'b1;
      end
      @(negedge clk);
      chk("rdy_hold", {127'b0, get_rdy(is_d)}, 128'd1);
      chk("line_hold", get_line(is_d), exp);
    end
    memI_filled_ack = 1'b0;
    memD_filled_ack = 1'b0;
    if (is_d) memD_filled_ack = 1'b1; else memI_filled_ack = 1'b1;
    @(negedge clk);
    memI_filled_ack = 1'b0;
    memD_filled_ack = 1'b0;
    chk("rdy_fall", {127'b0, get_rdy(is_d)}, 128'd0);
    chk("line_after", get_line(is_d), exp);
  endtask

  // Full transaction; request is dropped one cycle after acceptance and the
  // address/data inputs are scrambled to prove they are ignored while busy.
  task automatic txn(input bit is_d, input bit wrt, input logic [ADDR_W-1:0] addr,
                     input logic [LINE_W-1:0] data, input int ack_dly, input bit stray);
    logic [LINE_W-1:0] exp;
    int idx;
    idx = line_idx(addr);
    exp = (is_d && wrt) ? data : model[idx];
    @(negedge clk);
    if (is_d) begin
      reqD_mem = 1'b1; reqD_wrt = wrt; reqAddrD_mem = addr; wrt_data_D = data;
    end else begin
      reqI_mem = 1'b1; reqAddrI_mem = addr;
    end
    @(negedge clk);
    reqD_mem = 1'b0; reqI_mem = 1'b0;
    reqD_wrt = ~wrt; reqAddrD_mem = ADDR_W'($urandom); reqAddrI_mem = ADDR_W'($urandom);
    wrt_data_D = rnd_line();
    if (is_d && wrt) begin
      model[idx] = data;
      written.push_back(idx);
    end
    resp_phase(is_d, exp, ack_dly, stray);
  endtask

  initial begin
    logic [LINE_W-1:0] y, z;
    reset = 1'b1;
    reqI_mem = 0; reqAddrI_mem = '0; memI_filled_ack = 0;
    reqD_mem = 0; reqD_wrt = 0; reqAddrD_mem = '0; wrt_data_D = '0; memD_filled_ack = 0;
    repeat (3) @(negedge clk);
    chk("rst_rdyI", {127'b0, memI_data_rdy}, 128'd0);
    chk("rst_rdyD", {127'b0, memD_data_rdy}, 128'd0);
    chk("rst_lineI", memI_line, 128'd0);
    chk("rst_lineD", memD_line, 128'd0);
    reset = 1'b0;

    // D write then I read
    txn(1, 1, 20'h00040, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001, 0, 0);
    txn(0, 0, 20'h00040, '0, 0, 0);
    // offset and wrap
    txn(0, 0, 20'h0004C, '0, 1, 0);
    txn(0, 0, 20'h00040 + DEPTH*16, '0, 2, 0);
    txn(1, 0, 20'hF004F, '0, 0, 0);

    // simultaneous: D write to 0x80 wins, I read of 0x80 then sees it
    y = rnd_line();
    @(negedge clk);
    reqD_mem = 1; reqD_wrt = 1; reqAddrD_mem = 20'h00080; wrt_data_D = y;
    reqI_mem = 1; reqAddrI_mem = 20'h00080;
    @(negedge clk);
    reqD_mem = 0;
    model[8] = y; written.push_back(8);
    resp_phase(1, y, 0, 0);
    @(negedge clk);
    reqI_mem = 0;
    resp_phase(0, y, 0, 0);

    // held ack with stray D ack
    txn(0, 0, 20'h00040, '0, 10, 1);

    // reset two cycles after accepting a D write
    z = rnd_line();
    @(negedge clk);
    reqD_mem = 1; reqD_wrt = 1; reqAddrD_mem = 20'h00040; wrt_data_D = z;
    @(negedge clk);
    reqD_mem = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_rdyD", {127'b0, memD_data_rdy}, 128'd0);
    chk("mid_rst_rdyI", {127'b0, memI_data_rdy}, 128'd0);
    chk("mid_rst_lineD", memD_line, 128'd0);
    chk("mid_rst_lineI", memI_line, 128'd0);
    txn(0, 0, 20'h00040, '0, 0, 0);
    txn(1, 0, 20'h00040, '0, 0, 0);

    // randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      bit is_d, wrt;
      int idx;
      logic [ADDR_W-1:0] a;
      is_d = 1'($urandom);
      wrt  = is_d && ($urandom_range(0, 1) == 1);
      if (wrt) idx = $urandom_range(0, DEPTH-1);
      else     idx = written[$urandom_range(0, written.size()-1)];
      a = {4'($urandom), 8'(idx), 4'($urandom)};
      txn(is_d, wrt, a, rnd_line(), $urandom_range(0, 3), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/main_memory.md
# main_memory

Backing main memory model that serves instruction-cache line refills for the fetch stage and data-cache line reads/writes for the memory stage. It sits directly upstream of the fetch stage: it consumes `reqI_mem`/`reqAddrI_mem` and returns a full ICache line with a ready/ack handshake. A single shared array is accessed one transaction at a time, with fixed-priority arbitration and a programmable access latency.

## Interface
- `LINE_W`, 128: line width in bits. Equals the ICache/DCache line width.
- `ADDR_W`, 20: request address width, as a byte address.
- `DEPTH`, 256: number of lines in the array. Must be a power of 2.
- `LATENCY`, 5: cycles from request acceptance to data ready. Must be ≥1.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `reqI_mem`  in  1: instruction line read request. Held by fetch until `memI_data_rdy`.
- `reqAddrI_mem`  in  ADDR_W: byte address of the instruction line.
- `memI_line`  out  LINE_W: returned instruction line.
- `memI_data_rdy`  out  1: instruction line valid.
- `memI_filled_ack`  in  1: fetch has written the line into the ICache.
- `reqD_mem`  in  1: data request.
- `reqD_wrt`  in  1: 1 = write line, 0 = read line.
- `reqAddrD_mem`  in  ADDR_W: data byte address.
- `wrt_data_D`  in  LINE_W: write line data.
- `memD_line`  out  LINE_W: returned data line.
- `memD_data_rdy`  out  1: read data valid, or write complete.
- `memD_filled_ack`  in  1: data-side acknowledge.

## Operation
- Line index is `addr[log2(LINE_W/8)+log2(DEPTH)-1 : log2(LINE_W/8)]`. Offset bits are ignored. Upper bits are ignored, so addresses wrap modulo DEPTH lines.
- The array is not cleared by reset. Lines that were never written read as X.
- **FSM states:**
  - IDLE → BUSY_I or BUSY_D on an accepted request.
  - BUSY_x → RESP_x when the latency counter expires.
  - RESP_x → IDLE when the matching ack is sampled high.
- **Arbitration in IDLE:** data wins over instruction when both requests are high on the same edge. The losing request stays pending (requester holds it) and is taken at the next IDLE.
- **On acceptance:** the address, direction and write data are latched. The counter is loaded with LATENCY-1.
- **In BUSY_x:** requester inputs are ignored. Dropping the request does not abort; the transaction completes and waits for ack.
- **Entering RESP_D:**
  - Read: `memD_line` ← array[idx].
  - Write: array[idx] ← latched data; `memD_line` holds the written data.
- **Entering RESP_I:** `memI_line` ← array[idx].
- `memx_data_rdy` = 1 exactly while in RESP_x. Line outputs are stable for the whole RESP_x interval and hold their last value afterwards.
- An ack received while not in the matching RESP state is ignored, including an ack on the other port.
- Reset (at any state, including mid-transaction): state → IDLE, counter → 0, both `rdy` → 0, both line outputs → 0. A write in flight that has not reached RESP_D is discarded.

## Timing
- Request high at edge T while IDLE: accepted at T.
- `rdy` rises at edge T+LATENCY, so it is visible in the cycle after that edge.
- Ack high at edge A while in RESP: `rdy` falls at A and state becomes IDLE at A.
- The earliest next acceptance is edge A+1, so there is at least one IDLE cycle between transactions.
- Back-to-back request period is therefore LATENCY+2 cycles with an immediate ack.
- Ack on the same cycle `rdy` first becomes visible is legal; `rdy` stays high for exactly 1 cycle.
- Reset output values: `memI_data_rdy`=0, `memD_data_rdy`=0, `memI_line`=0, `memD_line`=0.

## Test plan
- **D write then I read:** write line `128'hDEAD..0001` at address 0x40, then fetch reads 0x40. Required:
  - `memD_data_rdy` rises 5 edges after acceptance.
  - After ack, `memI_line`=`128'hDEAD..0001` with `memI_data_rdy` rising 5 edges after the I request is accepted.
- **Simultaneous requests:** `reqI_mem`=`reqD_mem`=1 on the same edge. Required: the D transaction is served first; I is accepted at edge ack_D+1; I data is correct.
- **Held ack:** fetch delays `memI_filled_ack` by 10 cycles. Required: `memI_data_rdy` and `memI_line` are stable for all 10 cycles and fall on the ack edge; a stray `memD_filled_ack` during this wait has no effect.
- **Address wrap and offset:** write to 0x40, then read 0x4C and 0x40+DEPTH×16. Required: both reads return the same line.
- **Reset mid-BUSY:** reset asserted 2 cycles after accepting a D write. Required:
  - Next edge: outputs are 0 and state is IDLE.
  - A later read of that address returns the prior contents, not the aborted write.
- **Request dropped during BUSY:** `reqI_mem` deasserted 1 cycle after acceptance. Required: `memI_data_rdy` still rises at T+LATENCY and holds until ack.
